// File: rtl/filter_fetch_ctrl.sv
// ============================================================================
// filter_fetch_ctrl - sequences 27-tap filter reads from the weight ROM and
// streams them out over valid/ready.                            Rev 1.0
// ============================================================================
`default_nettype none

module filter_fetch_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 9,
  parameter int TAPS        = 27,
  parameter int NUM_FILTERS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        filter_sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] w_data,
  output logic [4:0]        w_index,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [4:0] C_LAST_TAP = 5'(TAPS - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_issue_cnt;
  logic [1:0]        r_credits;
  logic              r_pend;
  logic [4:0]        r_pend_idx;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [4:0]        r_fifo_idx  [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_done;
  logic              r_err;

  logic w_sel_ok;
  logic w_start_ok;
  logic w_start_bad;
  logic w_issue;
  logic w_hs;

  assign w_sel_ok = (32'(filter_sel) < NUM_FILTERS);
  assign w_valid  = (r_count != 2'd0);
  assign w_hs     = w_valid && w_ready;
  assign w_data   = r_fifo_data[r_rd_ptr];
  assign w_index  = r_fifo_idx[r_rd_ptr];
  assign w_last   = w_valid && (w_index == C_LAST_TAP);
  assign rom_addr = r_addr;
  assign done     = r_done;
  assign err      = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = S_FETCH;
      S_FETCH: if (w_issue && (r_issue_cnt == C_LAST_TAP)) w_next_state = S_DRAIN;
      S_DRAIN: if (w_hs && w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // A start landing in the done cycle is dropped so the sequencer sees a clean gap.
  always_comb begin
    busy        = 1'b0;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start_ok  = start && !r_done && w_sel_ok;
        w_start_bad = start && !r_done && !w_sel_ok;
      end
      S_FETCH: begin
        busy    = 1'b1;
        w_issue = (r_credits != 2'd0) || w_hs;
      end
      S_DRAIN: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_credits   <= '0;
      r_pend      <= 1'b0;
      r_pend_idx  <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_idx[i]  <= '0;
      end
    end else begin
      r_done <= (r_state == S_DRAIN) && w_hs && w_last;
      r_err  <= w_start_bad;

      if (w_start_ok) begin
        r_base      <= ADDR_W'(filter_sel) * ADDR_W'(TAPS);
        r_issue_cnt <= '0;
        r_credits   <= 2'd2;
      end else begin
        r_credits <= r_credits + {1'b0, w_hs} - {1'b0, w_issue};
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt + 5'd1;
        end
      end

      if (w_issue) begin
        r_addr     <= r_base + ADDR_W'(r_issue_cnt);
        r_pend_idx <= r_issue_cnt;
      end
      r_pend <= w_issue;

      // ROM data for last cycle's issue is on rom_data now; credits guarantee room.
      if (r_pend) begin
        r_fifo_data[r_wr_ptr] <= rom_data;
        r_fifo_idx[r_wr_ptr]  <= r_pend_idx;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_hs) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_pend} - {1'b0, w_hs};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_filter_fetch_ctrl.sv
// ============================================================================
// tb_filter_fetch_ctrl - scoreboard bench for filter_fetch_ctrl.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_filter_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] filter_sel;
  logic       busy, done, err;
  logic [8:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] w_data;
  logic [4:0] w_index;
  logic       w_valid, w_ready, w_last;

  filter_fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .filter_sel(filter_sel),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .w_data    (w_data),
    .w_index   (w_index),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_last    (w_last)
  );

  always #5 clk = ~clk;

  // ROM contents mem[i] = i mod 256; output reflects the address issued last cycle.
  logic [7:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = 8'(i);
  assign rom_data = mem[rom_addr];

  int n_vec  = 0;
  int n_fail = 0;
  int exp_q[$];
  int hs_cnt = 0;
  int done_cnt = 0;
  int addr_seen = 0;
  int max_out = 0;
  logic [8:0] prev_addr = '0;
  logic stall_prev = 1'b0;
  logic last_prev = 1'b0;
  logic [7:0] held_data;
  logic [4:0] held_idx;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_filter(input int base);
    for (int i = 0; i < 27; i++) exp_q.push_back(((base + i) & 255) | (i << 8));
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int c = 0; c < budget && done_cnt == d0; c++) tick;
    chk("done_within_budget", done_cnt - d0, 1);
  endtask

  task automatic wait_hs(input int n);
    for (int c = 0; c < 200 && hs_cnt < n; c++) tick;
    chk("reached_tap", int'(hs_cnt >= n), 1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stream rules.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
      last_prev  = 1'b0;
      prev_addr  = rom_addr;
    end else begin
      if (rom_addr != prev_addr) addr_seen++;
      prev_addr = rom_addr;
      if (done) begin
        done_cnt++;
        chk("done_follows_last_hs", int'(last_prev), 1);
        chk("busy_low_with_done", int'(busy), 0);
      end
      if (stall_prev) begin
        chk("hold_valid", int'(w_valid), 1);
        chk("hold_data", int'(w_data), int'(held_data));
        chk("hold_index", int'(w_index), int'(held_idx));
      end
      if (w_valid && w_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_weight: got data %0d index %0d, expected none", w_data, w_index);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("w_data", int'(w_data), e & 255);
          chk("w_index", int'(w_index), e >> 8);
          chk("w_last", int'(w_last), int'((e >> 8) == 26));
        end
      end
      stall_prev = w_valid && !w_ready;
      held_data  = w_data;
      held_idx   = w_index;
      last_prev  = w_valid && w_ready && w_last;
      if (addr_seen - hs_cnt > max_out) max_out = addr_seen - hs_cnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; filter_sel = '0; w_ready = 1'b1;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_w_valid", int'(w_valid), 0);
    chk("rst_w_data", int'(w_data), 0);
    tick; tick;
    reset = 1'b0;
    tick;

    // Filter 2 at full rate: cycle-accurate timeline.
    push_filter(54);
    filter_sel = 4'd2; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      chk("t1_busy", int'(busy), int'(k <= 29));
      chk("t1_done", int'(done), int'(k == 30));
      chk("t1_w_valid", int'(w_valid), int'(k >= 3 && k <= 29));
      if (k >= 2) chk("t1_rom_addr", int'(rom_addr), 54 + ((k - 2 > 26) ? 26 : k - 2));
      tick;
    end
    chk("t1_queue_empty", exp_q.size(), 0);

    // Illegal filter select.
    filter_sel = 4'd9; start = 1'b1;
    tick;
    start = 1'b0;
    chk("t2_err_pulse", int'(err), 1);
    chk("t2_busy", int'(busy), 0);
    tick;
    chk("t2_err_clear", int'(err), 0);
    for (int k = 0; k < 3; k++) begin
      chk("t2_busy_idle", int'(busy), 0);
      chk("t2_no_valid", int'(w_valid), 0);
      chk("t2_addr_held", int'(rom_addr), 80);
      tick;
    end

    // Filter 7 with toggling ready and a 5-cycle stall at tap 10.
    hs_cnt = 0; addr_seen = 0; max_out = 0;
    push_filter(189);
    filter_sel = 4'd7; start = 1'b1; w_ready = 1'b1;
    tick;
    start = 1'b0;
    begin
      int d0;
      bit burst;
      d0 = done_cnt; burst = 1'b0;
      for (int c = 0; c < 400 && done_cnt == d0; c++) begin
        if (!burst && hs_cnt == 10) begin
          burst = 1'b1; w_ready = 1'b0;
          repeat (5) tick;
        end else begin
          w_ready = !w_ready;
          tick;
        end
      end
      chk("t3_done_seen", done_cnt - d0, 1);
    end
    chk("t3_all_delivered", hs_cnt, 27);
    chk("t3_max_outstanding", max_out, 2);
    chk("t3_queue_empty", exp_q.size(), 0);
    w_ready = 1'b1;
    tick;

    // Filter 1 with a second start at tap 5 that must be ignored.
    hs_cnt = 0;
    push_filter(27);
    begin
      int d0;
      d0 = done_cnt;
      filter_sel = 4'd1; start = 1'b1;
      tick;
      start = 1'b0;
      wait_hs(5);
      filter_sel = 4'd6; start = 1'b1;
      tick;
      start = 1'b0;
      chk("t4_no_err", int'(err), 0);
      chk("t4_still_busy", int'(busy), 1);
      wait_done(100);
      repeat (5) tick;
      chk("t4_single_done", done_cnt - d0, 1);
      chk("t4_queue_empty", exp_q.size(), 0);
    end

    // Reset while tap 12 of filter 4 is presented.
    hs_cnt = 0;
    push_filter(108);
    filter_sel = 4'd4; start = 1'b1;
    tick;
    start = 1'b0;
    wait_hs(12);
    w_ready = 1'b0;
    chk("t5_valid_before_rst", int'(w_valid), 1);
    chk("t5_index_before_rst", int'(w_index), 12);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_w_valid", int'(w_valid), 0);
    chk("t5_rst_w_data", int'(w_data), 0);
    chk("t5_rst_w_index", int'(w_index), 0);
    chk("t5_rst_w_last", int'(w_last), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_rom_addr", int'(rom_addr), 0);
    exp_q.delete();
    tick; tick;
    reset = 1'b0; w_ready = 1'b1;
    tick;
    chk("t5_idle_after_rst", int'(w_valid), 0);
    push_filter(0);
    filter_sel = 4'd0; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(100);
    chk("t5_queue_empty", exp_q.size(), 0);
    tick;

    // Back-to-back: start on the done cycle is dropped, the next one is taken.
    push_filter(135);
    filter_sel = 4'd5; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 100 && !done; c++) tick;
    chk("t6_done_seen", int'(done), 1);
    filter_sel = 4'd3; start = 1'b1;
    tick;
    chk("t6_start_on_done_ignored", int'(busy), 0);
    chk("t6_no_err", int'(err), 0);
    push_filter(81);
    tick;
    start = 1'b0;
    chk("t6_start_accepted", int'(busy), 1);
    wait_done(100);
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_addr_held", int'(rom_addr), 107);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/filter_fetch_ctrl.md
Name: filter_fetch_ctrl

Overview:
- Sequences reads of the 216-entry, 8-bit filter weight ROM: 8 filters x 27 taps (3x3x3).
- On a start command, walks the 27 addresses of the selected filter and absorbs the ROM's 1-cycle registered read latency.
- Delivers weights to the conv PE array over a valid/ready stream with backpressure.
- Sits between the layer sequencer (start/done) and the ROM (address/data).

Parameters:
- DATA_W, 8, weight width; equals the ROM data width.
- ADDR_W, 9, ROM address width.
- TAPS, 27, weights per filter.
- NUM_FILTERS, 8, filters stored in the ROM; NUM_FILTERS*TAPS must be at most 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- filter_sel  in  4  filter number, valid with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last weight handshake.
- err  out  1  one-cycle pulse when start carries filter_sel >= NUM_FILTERS.
- rom_addr  out  ADDR_W  registered ROM read address.
- rom_data  in  DATA_W  ROM output; valid the cycle after rom_addr was issued.
- w_data  out  DATA_W  weight value.
- w_index  out  5  tap index 0..TAPS-1 of w_data.
- w_valid  out  1  weight available.
- w_ready  in  1  consumer accepts; a transfer occurs when w_valid && w_ready.
- w_last  out  1  high with w_valid when w_index == TAPS-1.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - State returns to IDLE.
  - All outputs go to 0: rom_addr, w_data, w_index, w_valid, w_last, busy, done, err.
  - Internal counters, credits and FIFO are cleared.
  - In-flight ROM data arriving after reset is discarded.
- States:
  - IDLE
    - start with filter_sel < NUM_FILTERS: latch base = filter_sel*TAPS, clear counters, go to FETCH.
    - start with filter_sel >= NUM_FILTERS: pulse err next cycle, stay in IDLE, never assert busy.
  - FETCH
    - Issue reads while credits > 0.
    - After the 27th issue, go to DRAIN.
  - DRAIN
    - Wait for the last handshake (w_last && w_ready).
    - Then pulse done for one cycle, deassert busy in that same cycle, and return to IDLE.
- Issue rule:
  - 2 credits. An issue in cycle t drives rom_addr = base + issue_cnt (registered) and consumes one credit.
  - rom_data is captured into a 2-entry output FIFO at the end of cycle t+1, tagged with its tap index.
  - One credit is returned per output handshake. A return and a consume in the same cycle leave the count unchanged.
  - The FIFO therefore never overflows; no ROM data is ever dropped.
- Throughput and latency:
  - With w_ready held high: one weight per cycle after a 3-cycle start-up.
  - start accepted at edge 0; first issue in cycle 1; first w_valid in cycle 3.
  - All 27 weights take 27 consecutive cycles (cycles 3..29); done pulses in cycle 30.
- Stream rules:
  - w_data, w_index and w_last hold stable while w_valid && !w_ready.
  - w_valid never drops without a handshake.
  - Weights appear strictly in tap order 0..26.
- rom_addr holds its last value when no read is issued. Arithmetic is unsigned; base + 26 <= 215, so there is no wrap.
- Commands while busy:
  - start while busy is ignored (no err, no restart).
  - A start in the same cycle as done is ignored; the next start is accepted from the following cycle.
- w_ready low for the whole DRAIN period stalls indefinitely; there is no timeout.

Test Plan:
- ROM preloaded with mem[i] = i mod 256; start, filter_sel=2, w_ready=1 -> rom_addr 54..80 consecutively; w_data 54..80 with w_index 0..26; w_last only on w_data 80; done exactly 1 cycle after that handshake; busy high throughout.
- filter_sel=7, w_ready toggling 1/0 every cycle plus a 5-cycle low burst at tap 10 -> all weights 189..215 delivered in order, no duplicates or drops; never more than 2 reads outstanding or buffered; w_data stable while stalled.
- start with filter_sel=9 -> err pulses 1 cycle; busy, w_valid and rom_addr activity stay 0.
- start pulsed again at tap 5 of a filter-1 fetch -> ignored; sequence 27..53 completes unchanged; a single done.
- reset asserted while w_valid=1 at tap 12 -> all outputs 0 immediately, without waiting for a clock edge; after release, start filter_sel=0 -> clean sequence 0..26 with no stale data emitted.
- Back-to-back: start filter 3 issued the cycle after done -> accepted; addresses 81..107 stream; the first start pulse coinciding with done is shown to be ignored.
